kernel_config_ctrl: RTL and testbench

- Sequences the Gaussian kernel generator (sigma, kernel_size -> normalized MAX_KERNEL x MAX_KERNEL 8-bit kernel; start pulse in; done pulse and err out).
- Arbitrates configuration requests from NUM_REQ convolution engines with round-robin priority.
- Caches the currently loaded configuration, so a matching request is acknowledged without regenerating the kernel.
- Validates requests, and reports generator errors and stale kernels.

---
 rtl/kernel_config_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_kernel_config_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_config_ctrl.sv
// Round-robin configuration controller for the Gaussian kernel generator with a one-entry config cache.
// Optional generator watchdog: define KCTRL_TIMEOUT_EN (limit TIMEOUT_CYC cycles in WAIT).
module kernel_config_ctrl #(
   parameter int NUM_REQ     = 2,
   parameter int MAX_KERNEL  = 3,
   parameter int KS_W        = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*3-1:0]    req_sigma,
   input  logic [NUM_REQ*KS_W-1:0] req_ksize,
   output logic [NUM_REQ-1:0]      ack,
   output logic                    ack_err,
   output logic                    gen_start,
   output logic [2:0]              gen_sigma,
   output logic [KS_W-1:0]         gen_kernel_size,
   input  logic                    gen_done,
   input  logic                    gen_err,
   output logic                    kernel_valid,
   output logic [2:0]              cur_sigma,
   output logic [KS_W-1:0]         cur_ksize,
   output logic                    busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("kernel_config_ctrl: unsupported NUM_REQ or TIMEOUT_CYC");
   end

   typedef enum logic [2:0] {IDLE, CHECK, START, WAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
   logic [2:0]          sel_sigma_q, sel_sigma_d;
   logic [KS_W-1:0]     sel_ksize_q, sel_ksize_d;
   logic                sticky_q, sticky_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                ack_err_q, ack_err_d;
   logic                gen_start_q, gen_start_d;
   logic [2:0]          gen_sigma_q, gen_sigma_d;
   logic [KS_W-1:0]     gen_ks_q, gen_ks_d;
   logic                kernel_valid_q, kernel_valid_d;
   logic [2:0]          cur_sigma_q, cur_sigma_d;
   logic [KS_W-1:0]     cur_ksize_q, cur_ksize_d;
`ifdef KCTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
`endif

   logic                found;
   logic [IDX_W-1:0]    pick_idx;
   logic                gen_fail;

   // A legal kernel is odd, non-zero and no larger than MAX_KERNEL, with non-zero sigma.
   function automatic logic cfg_ok(input logic [2:0] s, input logic [KS_W-1:0] k);
      return (s != 3'd0) && k[0] && (int'(k) <= MAX_KERNEL);
   endfunction

   always_comb begin
      int j;
      j        = 0;
      found    = 1'b0;
      pick_idx = rr_ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(rr_ptr_q) + i) % NUM_REQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            pick_idx = IDX_W'(j);
         end
      end
   end

   assign gen_fail = sticky_q | gen_err;

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      sel_idx_d      = sel_idx_q;
      sel_sigma_d    = sel_sigma_q;
      sel_ksize_d    = sel_ksize_q;
      sticky_d       = sticky_q;
      ack_d          = '0;
      ack_err_d      = 1'b0;
      gen_start_d    = 1'b0;
      gen_sigma_d    = gen_sigma_q;
      gen_ks_d       = gen_ks_q;
      kernel_valid_d = kernel_valid_q;
      cur_sigma_d    = cur_sigma_q;
      cur_ksize_d    = cur_ksize_q;
`ifdef KCTRL_TIMEOUT_EN
      tmo_cnt_d      = tmo_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_idx_d   = pick_idx;
               sel_sigma_d = req_sigma[int'(pick_idx)*3 +: 3];
               sel_ksize_d = req_ksize[int'(pick_idx)*KS_W +: KS_W];
               state_d     = CHECK;
            end
         end
         CHECK: begin
            if (!cfg_ok(sel_sigma_q, sel_ksize_q)) begin
               state_d          = RESP;
               ack_d[sel_idx_q] = 1'b1;
               ack_err_d        = 1'b1;
            end else if (kernel_valid_q && sel_sigma_q == cur_sigma_q &&
                         sel_ksize_q == cur_ksize_q) begin
               state_d          = RESP;
               ack_d[sel_idx_q] = 1'b1;
            end else begin
               state_d     = START;
               gen_start_d = 1'b1;
               gen_sigma_d = sel_sigma_q;
               gen_ks_d    = sel_ksize_q;
            end
         end
         START: begin
            kernel_valid_d = 1'b0;
            sticky_d       = 1'b0;
            state_d        = WAIT;
`ifdef KCTRL_TIMEOUT_EN
            tmo_cnt_d      = '0;
`endif
         end
         WAIT: begin
            sticky_d = gen_fail;
            if (gen_done) begin
               state_d          = RESP;
               ack_d[sel_idx_q] = 1'b1;
               ack_err_d        = gen_fail;
               if (!gen_fail) begin
                  cur_sigma_d    = sel_sigma_q;
                  cur_ksize_d    = sel_ksize_q;
                  kernel_valid_d = 1'b1;
               end
            end
`ifdef KCTRL_TIMEOUT_EN
            // Abandon a generator that never finishes; the kernel stays invalid.
            else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d          = RESP;
               ack_d[sel_idx_q] = 1'b1;
               ack_err_d        = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            rr_ptr_d = (int'(sel_idx_q) == NUM_REQ - 1) ? '0 : sel_idx_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         rr_ptr_q       <= '0;
         sel_idx_q      <= '0;
         sel_sigma_q    <= '0;
         sel_ksize_q    <= '0;
         sticky_q       <= 1'b0;
         ack_q          <= '0;
         ack_err_q      <= 1'b0;
         gen_start_q    <= 1'b0;
         gen_sigma_q    <= '0;
         gen_ks_q       <= '0;
         kernel_valid_q <= 1'b0;
         cur_sigma_q    <= '0;
         cur_ksize_q    <= '0;
`ifdef KCTRL_TIMEOUT_EN
         tmo_cnt_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         sel_idx_q      <= sel_idx_d;
         sel_sigma_q    <= sel_sigma_d;
         sel_ksize_q    <= sel_ksize_d;
         sticky_q       <= sticky_d;
         ack_q          <= ack_d;
         ack_err_q      <= ack_err_d;
         gen_start_q    <= gen_start_d;
         gen_sigma_q    <= gen_sigma_d;
         gen_ks_q       <= gen_ks_d;
         kernel_valid_q <= kernel_valid_d;
         cur_sigma_q    <= cur_sigma_d;
         cur_ksize_q    <= cur_ksize_d;
`ifdef KCTRL_TIMEOUT_EN
         tmo_cnt_q      <= tmo_cnt_d;
`endif
      end
   end

   assign ack             = ack_q;
   assign ack_err         = ack_err_q;
   assign gen_start       = gen_start_q;
   assign gen_sigma       = gen_sigma_q;
   assign gen_kernel_size = gen_ks_q;
   assign kernel_valid    = kernel_valid_q;
   assign cur_sigma       = cur_sigma_q;
   assign cur_ksize       = cur_ksize_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_kernel_config_ctrl.sv
// Scoreboard bench for kernel_config_ctrl: directed requests, expected acks/starts queued, monitor compares.
module tb_kernel_config_ctrl;
   localparam int NUM_REQ = 2;
   localparam int KS_W    = 2;

   logic                    clk = 1'b0;
   logic                    n_rst;
   logic [NUM_REQ-1:0]      req;
   logic [NUM_REQ*3-1:0]    req_sigma;
   logic [NUM_REQ*KS_W-1:0] req_ksize;
   logic [NUM_REQ-1:0]      ack;
   logic                    ack_err;
   logic                    gen_start;
   logic [2:0]              gen_sigma;
   logic [KS_W-1:0]         gen_kernel_size;
   logic                    gen_done;
   logic                    gen_err;
   logic                    kernel_valid;
   logic [2:0]              cur_sigma;
   logic [KS_W-1:0]         cur_ksize;
   logic                    busy;

   kernel_config_ctrl #(.NUM_REQ(NUM_REQ), .MAX_KERNEL(3), .KS_W(KS_W), .TIMEOUT_CYC(255)) dut (
      .clk(clk), .n_rst(n_rst), .req(req), .req_sigma(req_sigma), .req_ksize(req_ksize),
      .ack(ack), .ack_err(ack_err), .gen_start(gen_start), .gen_sigma(gen_sigma),
      .gen_kernel_size(gen_kernel_size), .gen_done(gen_done), .gen_err(gen_err),
      .kernel_valid(kernel_valid), .cur_sigma(cur_sigma), .cur_ksize(cur_ksize), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [NUM_REQ-1:0] a; logic err; int c;} ack_exp_t;
   typedef struct {logic [2:0] s; logic [KS_W-1:0] k;} gen_exp_t;
   ack_exp_t ack_q[$];
   gen_exp_t gen_q[$];
   ack_exp_t aexp;
   gen_exp_t gexp;
   int n_chk = 0;
   int n_fail = 0;
   int s_cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic request(input int idx, input int s, input int k);
      req_sigma[idx*3 +: 3]       = 3'(s);
      req_ksize[idx*KS_W +: KS_W] = KS_W'(k);
      req[idx]                    = 1'b1;
   endtask

   task automatic push_ack(input int idx, input logic err, input int c);
      ack_exp_t e;
      e.a      = '0;
      e.a[idx] = 1'b1;
      e.err    = err;
      e.c      = c;
      ack_q.push_back(e);
   endtask

   task automatic push_gen(input int s, input int k);
      gen_exp_t g;
      g.s = 3'(s);
      g.k = KS_W'(k);
      gen_q.push_back(g);
   endtask

   task automatic wait_start(input int exp_cyc, output int s);
      int t = 0;
      while (gen_start !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (gen_start !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL gen_start_timeout: got no start in 20 cycles, expected start at cycle %0d", exp_cyc);
      end
      chk("gen_start_cycle", cyc, exp_cyc);
      s = cyc;
   endtask

   // Generator model: done after lat cycles, optional one-cycle err pulse at err_off.
   task automatic finish_gen(input int idx, input int lat, input int err_off, input logic exp_err);
      for (int i = 1; i <= lat; i++) begin
         @(negedge clk);
         gen_err = (i == err_off);
         if (i == lat) begin
            push_ack(idx, exp_err, cyc + 1);
            gen_done = 1'b1;
         end
      end
      @(negedge clk);
      gen_done = 1'b0;
      gen_err  = 1'b0;
   endtask

   task automatic wait_ack(input int idx, input logic drop);
      int t = 0;
      while (ack === '0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (ack === '0) begin
         n_chk++;
         n_fail++;
         $display("FAIL ack_timeout: got no ack in 400 cycles, expected ack for engine %0d", idx);
      end
      if (drop) req[idx] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      n_rst     = 1'b0;
      req       = '0;
      req_sigma = '0;
      req_ksize = '0;
      gen_done  = 1'b0;
      gen_err   = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (n_rst === 1'b1) begin
               if (gen_start !== 1'b0) begin
                  if (gen_q.size() == 0) begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL gen_start_unexpected: got start sigma=%0d ksize=%0d, expected none",
                              gen_sigma, gen_kernel_size);
                  end else begin
                     gexp = gen_q.pop_front();
                     chk("gen_sigma", 32'(gen_sigma), 32'(gexp.s));
                     chk("gen_kernel_size", 32'(gen_kernel_size), 32'(gexp.k));
                  end
               end
               if (ack !== '0) begin
                  if (ack_q.size() == 0) begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL ack_unexpected: got ack=%b err=%b, expected none", ack, ack_err);
                  end else begin
                     aexp = ack_q.pop_front();
                     chk("ack", 32'(ack), 32'(aexp.a));
                     chk("ack_err", 32'(ack_err), 32'(aexp.err));
                     chk("ack_cycle", cyc, aexp.c);
                  end
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_ack_err", 32'(ack_err), 0);
      chk("rst_gen_start", 32'(gen_start), 0);
      chk("rst_gen_sigma", 32'(gen_sigma), 0);
      chk("rst_gen_kernel_size", 32'(gen_kernel_size), 0);
      chk("rst_kernel_valid", 32'(kernel_valid), 0);
      chk("rst_cur_sigma", 32'(cur_sigma), 0);
      chk("rst_cur_ksize", 32'(cur_ksize), 0);
      chk("rst_busy", 32'(busy), 0);
      n_rst = 1'b1;

      // Miss on engine 0 after reset
      @(negedge clk);
      request(0, 2, 3);
      push_gen(2, 3);
      wait_start(cyc + 2, s_cyc);
      finish_gen(0, 10, 0, 1'b0);
      wait_ack(0, 1'b1);
      chk("t1_kernel_valid", 32'(kernel_valid), 1);
      chk("t1_cur_sigma", 32'(cur_sigma), 2);
      chk("t1_cur_ksize", 32'(cur_ksize), 3);

      // Engine 1 hits the cache
      @(negedge clk);
      request(1, 2, 3);
      push_ack(1, 1'b0, cyc + 2);
      wait_ack(1, 1'b1);

      // Both engines, rr pointer back at 0
      @(negedge clk);
      request(0, 1, 3);
      request(1, 3, 3);
      push_gen(1, 3);
      wait_start(cyc + 2, s_cyc);
      finish_gen(0, 4, 0, 1'b0);
      wait_ack(0, 1'b1);
      push_gen(3, 3);
      wait_start(cyc + 3, s_cyc);
      finish_gen(1, 4, 0, 1'b0);
      wait_ack(1, 1'b1);
      chk("t3_cur_sigma", 32'(cur_sigma), 3);
      chk("t3_kernel_valid", 32'(kernel_valid), 1);

      // Invalid requests: even ksize, then zero sigma
      @(negedge clk);
      request(0, 1, 2);
      push_ack(0, 1'b1, cyc + 2);
      wait_ack(0, 1'b1);
      @(negedge clk);
      request(1, 0, 3);
      push_ack(1, 1'b1, cyc + 2);
      wait_ack(1, 1'b1);
      chk("t4_kernel_valid", 32'(kernel_valid), 1);
      chk("t4_cur_sigma", 32'(cur_sigma), 3);

      // Generator error mid-WAIT, then the same request misses again
      @(negedge clk);
      request(0, 1, 1);
      push_gen(1, 1);
      wait_start(cyc + 2, s_cyc);
      finish_gen(0, 6, 3, 1'b1);
      wait_ack(0, 1'b1);
      chk("t5_kernel_valid_err", 32'(kernel_valid), 0);
      chk("t5_cur_sigma_kept", 32'(cur_sigma), 3);
      @(negedge clk);
      request(0, 1, 1);
      push_gen(1, 1);
      wait_start(cyc + 2, s_cyc);
      finish_gen(0, 3, 0, 1'b0);
      wait_ack(0, 1'b1);
      chk("t5_kernel_valid_retry", 32'(kernel_valid), 1);
      chk("t5_cur_sigma_retry", 32'(cur_sigma), 1);

      // Reset during WAIT; held request is re-served afterwards
      @(negedge clk);
      request(1, 3, 3);
      push_gen(3, 3);
      wait_start(cyc + 2, s_cyc);
      repeat (3) @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_kernel_valid", 32'(kernel_valid), 0);
      chk("t6_rst_gen_sigma", 32'(gen_sigma), 0);
      chk("t6_rst_cur_sigma", 32'(cur_sigma), 0);
      chk("t6_rst_ack", 32'(ack), 0);
      @(negedge clk);
      n_rst = 1'b1;
      push_gen(3, 3);
      wait_start(cyc + 2, s_cyc);
      finish_gen(1, 5, 0, 1'b0);
      wait_ack(1, 1'b1);
      chk("t6_cur_sigma", 32'(cur_sigma), 3);

      // Stray gen_done while idle
      @(negedge clk);
      gen_done = 1'b1;
      @(negedge clk);
      gen_done = 1'b0;
      @(negedge clk);
      chk("stray_done_busy", 32'(busy), 0);
      chk("stray_done_kernel_valid", 32'(kernel_valid), 1);

`ifdef KCTRL_TIMEOUT_EN
      // Generator never finishes: watchdog fails the request
      @(negedge clk);
      request(0, 2, 1);
      push_gen(2, 1);
      wait_start(cyc + 2, s_cyc);
      push_ack(0, 1'b1, s_cyc + 256);
      wait_ack(0, 1'b1);
      @(negedge clk);
      gen_done = 1'b1;
      @(negedge clk);
      gen_done = 1'b0;
      @(negedge clk);
      chk("tmo_kernel_valid", 32'(kernel_valid), 0);
      chk("tmo_busy", 32'(busy), 0);
`endif

      repeat (5) @(negedge clk);
      chk("ack_queue_drained", ack_q.size(), 0);
      chk("gen_queue_drained", gen_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
